operand_sequencer: RTL



---
 rtl/operand_sequencer_pkg.sv | 24 ++
 rtl/opseq_index_counter.sv | 79 +++++++
 rtl/operand_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/operand_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// operand_sequencer_pkg
//
// Shared definitions for the operand sequencer slice:
//   state_e        - sequencer FSM states (IDLE, RUN, DONE)
//   DEFAULT_DEPTH  - default number of entries in each operand table
//   idx_w_f()      - index width for a given table depth (never below 1 bit)
// -----------------------------------------------------------------------------
package operand_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_DEPTH = 5;

  // A depth of 1 still needs one address bit so the idx port has a legal width.
  function automatic int idx_w_f(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage : operand_sequencer_pkg

// File: rtl/opseq_index_counter.sv
// -----------------------------------------------------------------------------
// opseq_index_counter
//
// Table index and transfer count registers for the operand sequencer.
//
// Ports:
//   ck        in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   clear     in   zero idx and count (start of a pass)
//   advance   in   one transfer accepted this cycle
//   hold_idx  in   count the transfer but keep idx (run is being aborted)
//   wrap      in   transfer at the final entry restarts idx/count at zero
//   limit     in   effective pass length; idx stops at limit-1, count at limit
//   idx       out  current table address
//   count     out  transfers completed in the current pass
// -----------------------------------------------------------------------------
module opseq_index_counter
  import operand_sequencer_pkg::*;
#(
  parameter int IDX_W = idx_w_f(DEFAULT_DEPTH)
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  input  logic             hold_idx,
  input  logic             wrap,
  input  logic [IDX_W:0]   limit,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W:0]   count
);

  logic [IDX_W-1:0] idx_d, idx_q;
  logic [IDX_W:0]   count_d, count_q;
  logic             at_end;

  // idx+1 >= limit  <=>  idx is already on the final entry, so it must not move.
  // Computed one bit wider so idx = 2**IDX_W - 1 cannot overflow the compare.
  assign at_end = ({1'b0, idx_q} + (IDX_W+1)'(1)) >= limit;

  always_comb begin
    // NOTE: every *_d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    idx_d   = idx_q;
    count_d = count_q;
    if (clear) begin
      idx_d   = '0;
      count_d = '0;
    end else if (advance) begin
      if (wrap) begin
        idx_d   = '0;
        count_d = '0;
      end else begin
        if (!hold_idx && !at_end) begin
          idx_d = idx_q + IDX_W'(1);
        end
        if (count_q < limit) begin
          count_d = count_q + (IDX_W+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (!rst_n) begin
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  assign idx   = idx_q;
  assign count = count_q;

endmodule : opseq_index_counter

// File: rtl/operand_sequencer.sv
// -----------------------------------------------------------------------------
// operand_sequencer
//
// Steps the A/B/C operand table address under a valid/ready handshake. A pass
// is started from IDLE, offers len_eff = min(len, DEPTH) triples in order,
// advances only on accepted transfers and pulses done when the pass completes.
// abort returns to IDLE from anywhere without a done pulse.
//
// Optional feature macro: OPERAND_SEQUENCER_LOOP_EN
//   When defined, adds input 'loop' (latched on start). With loop=1 a transfer
//   at the final entry wraps to idx 0 and the run continues until abort/reset.
//
// Ports:
//   ck     in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   begin a pass (sampled only in IDLE)
//   len    in   entries to issue, latched on an accepted start
//   abort  in   terminate the run; wins over every other event
//   ready  in   consumer accepts the current triple
//   loop   in   (OPERAND_SEQUENCER_LOOP_EN only) continuous-loop select
//   idx    out  table address for A/B/C
//   valid  out  idx addresses a triple offered to the consumer
//   last   out  current triple is the final entry of the pass
//   busy   out  sequencer is not in IDLE
//   done   out  one-cycle pulse, pass completed normally
//   count  out  transfers completed in the current pass
// -----------------------------------------------------------------------------
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int IDX_W = idx_w_f(DEPTH)
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W:0]   len,
  input  logic             abort,
  input  logic             ready,
`ifdef OPERAND_SEQUENCER_LOOP_EN
  input  logic             loop,
`endif
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic [IDX_W:0]   count
);

  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

  state_e         state_d, state_q;
  logic           valid_d, valid_q;
  logic           busy_d, busy_q;
  logic           done_d, done_q;
  logic           loop_d, loop_q;
  logic [IDX_W:0] len_d, len_q;

  logic           loop_in;
  logic [IDX_W:0] len_clamped;
  logic           transfer;
  logic           at_last;
  logic           cnt_clear;
  logic           cnt_wrap;

`ifdef OPERAND_SEQUENCER_LOOP_EN
  assign loop_in = loop;
`else
  assign loop_in = 1'b0;
`endif

  assign len_clamped = (len > DEPTH_L) ? DEPTH_L : len;
  assign transfer    = valid_q & ready;

  // len_q - 1 underflows to all ones when len_q is 0, which never matches the
  // zero-extended idx; valid is low in that case anyway.
  assign at_last = ({1'b0, idx} == (len_q - (IDX_W+1)'(1)));

  // An aborted final transfer is still counted but must not wrap the loop.
  assign cnt_wrap = transfer & at_last & loop_q & ~abort;

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    len_d     = len_q;
    loop_d    = loop_q;
    cnt_clear = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          len_d     = len_clamped;
          loop_d    = loop_in;
          cnt_clear = 1'b1;
          busy_d    = 1'b1;
          if (len_clamped == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            valid_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (transfer && at_last && !loop_q) begin
          state_d = DONE;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        // done is already high for this single cycle; abort here has the
        // same effect as the normal exit.
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      len_q   <= '0;
      loop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
    end
  end

  opseq_index_counter #(
    .IDX_W (IDX_W)
  ) u_index_counter (
    .ck       (ck),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .advance  (transfer),
    .hold_idx (abort),
    .wrap     (cnt_wrap),
    .limit    (len_q),
    .idx      (idx),
    .count    (count)
  );

  assign valid = valid_q;
  assign last  = valid_q & at_last;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule : operand_sequencer
